// File: rtl/run_ctrl_pkg.sv
// Shared types and default widths for the run controller.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    RC_IDLE = 2'd0,
    RC_ARM  = 2'd1,
    RC_RUN  = 2'd2,
    RC_DONE = 2'd3
  } rc_state_e;

  localparam int RC_CNT_W  = 16;
  localparam int RC_RUNS_W = 8;

endpackage

// File: rtl/run_ctrl_if.sv
// Control/status bundle between a sequencing master and run_ctrl.
// The pause line exists only when RUN_CTRL_PAUSE_EN is defined.
interface run_ctrl_if #(
  parameter int CNT_W  = 16,
  parameter int RUNS_W = 8
);
  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  limit_val;
  logic [RUNS_W-1:0] runs;
`ifdef RUN_CTRL_PAUSE_EN
  logic              pause;
`endif
  logic              sreset;
  logic              busy;
  logic              done;
  logic              tick;
  logic [CNT_W-1:0]  cnt;
  logic [RUNS_W-1:0] run_idx;

`ifdef RUN_CTRL_PAUSE_EN
  modport master (output start, abort, limit_val, runs, pause,
                  input  sreset, busy, done, tick, cnt, run_idx);
  modport slave  (input  start, abort, limit_val, runs, pause,
                  output sreset, busy, done, tick, cnt, run_idx);
`else
  modport master (output start, abort, limit_val, runs,
                  input  sreset, busy, done, tick, cnt, run_idx);
  modport slave  (input  start, abort, limit_val, runs,
                  output sreset, busy, done, tick, cnt, run_idx);
`endif

endinterface

// File: rtl/run_ctrl_cnt.sv
// Cycle counter wrapping at limit plus a completed-run counter.
// last flags the wrap that finishes the final run of a finite sequence.
module run_ctrl_cnt
  import run_ctrl_pkg::*;
#(
  parameter int CNT_W  = RC_CNT_W,
  parameter int RUNS_W = RC_RUNS_W
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [CNT_W-1:0]  limit,
  input  logic [RUNS_W-1:0] runs,
  output logic              wrap,
  output logic              last,
  output logic [CNT_W-1:0]  cnt,
  output logic [RUNS_W-1:0] run_idx
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RUNS_W-1:0] idx_q, idx_d;
  logic [RUNS_W-1:0] idx_inc;

  assign idx_inc = idx_q + RUNS_W'(1);
  assign wrap    = en && (cnt_q == limit);
  // runs == 0 is the continuous mode, so it never produces a last wrap
  assign last    = wrap && (runs != '0) && (idx_inc == runs);

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (clr) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
      idx_d = idx_inc;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign cnt     = cnt_q;
  assign run_idx = idx_q;

endmodule

// File: rtl/run_ctrl.sv
// Run sequencer: IDLE -> ARM (soft reset, latch config) -> RUN -> DONE.
// Optional counter stall via pause when RUN_CTRL_PAUSE_EN is defined.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int CNT_W  = RC_CNT_W,
  parameter int RUNS_W = RC_RUNS_W
) (
  input logic       mclk,
  input logic       reset,
  run_ctrl_if.slave bus
);

  rc_state_e         state_q, state_d;
  logic [CNT_W-1:0]  limit_q, limit_d;
  logic [RUNS_W-1:0] runs_q, runs_d;
  logic              hold;
  logic              cnt_en;
  logic              wrap;
  logic              last;

`ifdef RUN_CTRL_PAUSE_EN
  assign hold = bus.pause;
`else
  assign hold = 1'b0;
`endif

  // a paused counter cannot wrap, so pause also suppresses tick and DONE
  assign cnt_en = (state_q == RC_RUN) && !hold;

  run_ctrl_cnt #(
    .CNT_W  (CNT_W),
    .RUNS_W (RUNS_W)
  ) u_cnt (
    .mclk    (mclk),
    .reset   (reset),
    .clr     (state_q == RC_ARM),
    .en      (cnt_en),
    .limit   (limit_q),
    .runs    (runs_q),
    .wrap    (wrap),
    .last    (last),
    .cnt     (bus.cnt),
    .run_idx (bus.run_idx)
  );

  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q <= RC_IDLE;
      limit_q <= '0;
      runs_q  <= '0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      runs_q  <= runs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    runs_d  = runs_q;
    unique case (state_q)
      RC_IDLE: if (bus.start) state_d = RC_ARM;
      RC_ARM: begin
        limit_d = bus.limit_val;
        runs_d  = bus.runs;
        state_d = bus.abort ? RC_IDLE : RC_RUN;
      end
      RC_RUN: begin
        if (bus.abort)  state_d = RC_IDLE;
        else if (last)  state_d = RC_DONE;
      end
      RC_DONE: begin
        if (bus.abort)      state_d = RC_IDLE;
        else if (bus.start) state_d = RC_ARM;
      end
      default: state_d = RC_IDLE;
    endcase
  end

  always_comb begin
    bus.sreset = (state_q != RC_RUN);
    bus.busy   = (state_q == RC_ARM) || (state_q == RC_RUN);
    bus.done   = (state_q == RC_DONE);
    bus.tick   = wrap;
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl; define RUN_CTRL_PAUSE_EN to include the pause case.
module tb_run_ctrl;

  localparam int CW = 16;
  localparam int RW = 8;

  logic mclk = 1'b0;
  logic reset;
  int   n_tot = 0;
  int   n_bad = 0;

  always #5 mclk = ~mclk;

  run_ctrl_if #(.CNT_W(CW), .RUNS_W(RW)) bus ();

  run_ctrl #(.CNT_W(CW), .RUNS_W(RW)) dut (
    .mclk  (mclk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  // Cycle c counts edges from the one that samples start (c=1 is ARM).
  // RUN spans c=2..1+nr*(lim+1); DONE follows when nr != 0.
  task automatic seq_check(input string tg, input int lim, input int nr,
                           input int ncyc, input bit disturb);
    int pl, len, r;
    pl  = lim + 1;
    len = nr * pl;
    bus.limit_val = CW'(lim);
    bus.runs      = RW'(nr);
    bus.start     = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      bus.start = (disturb && c >= 3 && c <= 5) ? 1'b1 : 1'b0;
      if (disturb && c >= 3) begin
        bus.limit_val = CW'(1);
        bus.runs      = RW'(7);
      end
      if (c == 1) begin
        chk({tg, "/arm_sreset"}, 32'(bus.sreset), 1);
        chk({tg, "/arm_busy"},   32'(bus.busy),   1);
        chk({tg, "/arm_done"},   32'(bus.done),   0);
      end else if (nr == 0 || c <= 1 + len) begin
        r = c - 2;
        chk({tg, "/cnt"},     32'(bus.cnt),     32'(r % pl));
        chk({tg, "/tick"},    32'(bus.tick),    32'((r % pl) == lim));
        chk({tg, "/run_idx"}, 32'(bus.run_idx), 32'((r / pl) % 256));
        chk({tg, "/sreset"},  32'(bus.sreset),  0);
        chk({tg, "/done"},    32'(bus.done),    0);
      end else begin
        chk({tg, "/done_done"},    32'(bus.done),    1);
        chk({tg, "/done_sreset"},  32'(bus.sreset),  1);
        chk({tg, "/done_busy"},    32'(bus.busy),    0);
        chk({tg, "/done_tick"},    32'(bus.tick),    0);
        chk({tg, "/done_cnt"},     32'(bus.cnt),     0);
        chk({tg, "/done_run_idx"}, 32'(bus.run_idx), 32'(nr));
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.limit_val = '0;
    bus.runs      = '0;
`ifdef RUN_CTRL_PAUSE_EN
    bus.pause     = 1'b0;
`endif
    repeat (3) step();
    chk("rst_sreset",  32'(bus.sreset),  1);
    chk("rst_busy",    32'(bus.busy),    0);
    chk("rst_done",    32'(bus.done),    0);
    chk("rst_tick",    32'(bus.tick),    0);
    chk("rst_cnt",     32'(bus.cnt),     0);
    chk("rst_run_idx", 32'(bus.run_idx), 0);
    reset = 1'b0;
    step();
    chk("idle_busy", 32'(bus.busy), 0);

    seq_check("l4r2", 4, 2, 13, 1'b0);
    seq_check("l0r3", 0, 3, 6, 1'b0);
    seq_check("l2cont", 2, 0, 1000, 1'b0);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("cont_abort_busy", 32'(bus.busy),   0);
    chk("cont_abort_sres", 32'(bus.sreset), 1);

    // abort at cnt=2 of the first run
    bus.limit_val = CW'(9);
    bus.runs      = RW'(2);
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (3) step();
    chk("ab_cnt2", 32'(bus.cnt), 2);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("ab_sreset", 32'(bus.sreset), 1);
    chk("ab_busy",   32'(bus.busy),   0);
    for (int i = 0; i < 25; i++) begin
      chk("ab_no_done", 32'(bus.done), 0);
      step();
    end

    // start and abort together in DONE
    seq_check("l1r2", 1, 2, 7, 1'b0);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("sa_done",   32'(bus.done),   0);
    chk("sa_busy",   32'(bus.busy),   0);
    chk("sa_sreset", 32'(bus.sreset), 1);
    step();
    chk("sa_stay_idle", 32'(bus.busy), 0);

    // start re-pulsed and config changed mid-RUN
    seq_check("dist", 4, 2, 13, 1'b1);

`ifdef RUN_CTRL_PAUSE_EN
    bus.limit_val = CW'(7);
    bus.runs      = RW'(1);
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (4) step();
    chk("p_cnt3", 32'(bus.cnt), 3);
    bus.pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("p_hold_cnt",  32'(bus.cnt),  3);
      chk("p_hold_tick", 32'(bus.tick), 0);
      chk("p_hold_busy", 32'(bus.busy), 1);
    end
    bus.pause = 1'b0;
    repeat (4) step();
    chk("p_cnt7", 32'(bus.cnt),  7);
    chk("p_tick", 32'(bus.tick), 1);
    chk("p_not_done", 32'(bus.done), 0);
    step();
    chk("p_done",    32'(bus.done),    1);
    chk("p_run_idx", 32'(bus.run_idx), 1);
`endif

    // reset mid-sequence
    bus.limit_val = CW'(5);
    bus.runs      = RW'(3);
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (8) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_busy",    32'(bus.busy),    0);
    chk("mr_sreset",  32'(bus.sreset),  1);
    chk("mr_cnt",     32'(bus.cnt),     0);
    chk("mr_run_idx", 32'(bus.run_idx), 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Parametrised run controller for the datapath: on `start` it pulses a downstream soft reset, then counts `limit_val+1` cycles per run for a programmable number of runs (or forever), and reports completion. It is the sequencing master between the testbench/top-level control inputs and the counting/processing blocks that consume `sreset`, `tick` and `done`, and it replaces the fixed three-state start/limit/done controller with abort, repeat and run counting.

## Interface
Parameters:
- `CNT_W`, 16: width of the cycle counter and of `limit_val`.
- `RUNS_W`, 8: width of the run counter and of `runs`.

Ports:
- `mclk`  in  1  clock; all logic on its rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  request a new sequence; sampled only in IDLE or DONE.
- `abort`  in  1  cancel the sequence; honoured in ARM, RUN and DONE.
- `limit_val`  in  CNT_W  last count value of each run; latched in ARM.
- `runs`  in  RUNS_W  number of runs; 0 means continuous; latched in ARM.
- `pause`  in  1  freeze the counter (present only with `RUN_CTRL_PAUSE_EN`).
- `sreset`  out  1  downstream soft reset.
- `busy`  out  1  high in ARM and RUN.
- `done`  out  1  high in DONE.
- `tick`  out  1  one-cycle pulse on each run wrap.
- `cnt`  out  CNT_W  current cycle count.
- `run_idx`  out  RUNS_W  number of completed runs.

## Operation
- States: IDLE, ARM, RUN, DONE. Moore decode: IDLE `sreset=1`; ARM `sreset=1, busy=1`; RUN `busy=1`; DONE `done=1, sreset=1`.
- IDLE/DONE + `start` -> ARM. ARM always lasts exactly one cycle -> RUN. In ARM: `cnt<=0`, `run_idx<=0`, `limit_q<=limit_val`, `runs_q<=runs`.
- RUN: `cnt` increments by 1 per cycle. When `cnt==limit_q`, `tick=1` (combinational, same cycle), `cnt<=0`, `run_idx<=run_idx+1`. If `runs_q!=0` and `run_idx+1==runs_q` -> DONE.
- `runs_q==0`: RUN continues indefinitely; `run_idx` wraps modulo 2^RUNS_W.
- `limit_q==0`: every RUN cycle is a wrap, so `tick` stays high continuously.
- `start` in ARM/RUN is ignored. `limit_val` and `runs` changes after ARM have no effect.
- `abort` in ARM/RUN/DONE -> IDLE next cycle. `abort` and `start` in the same cycle: abort wins. `done` never asserts on an aborted sequence.
- DONE holds `cnt` and `run_idx` until the next `start` or `abort`.

## Timing
- Reset values: state IDLE, `sreset=1`, `busy=0`, `done=0`, `tick=0`, `cnt=0`, `run_idx=0`, `limit_q=0`, `runs_q=0`. Reset mid-sequence takes effect at the next edge and overrides all inputs.
- `start` sampled at edge 0 -> ARM from edge 1 -> RUN from edge 2. `done` rises at edge `2 + runs*(limit_val+1)` with no pause.
- `sreset` is high for the single ARM cycle, then low for all of RUN.

## Configuration
- `RUN_CTRL_PAUSE_EN` defined: the `pause` port exists. In RUN with `pause=1`, `cnt` and `run_idx` hold, `tick` is forced to 0, and the state does not change. `abort` still wins over `pause`.
- Not defined: no `pause` port, and the counter never stalls.

## Structure
- `run_ctrl_pkg` holds the state enum (`RC_IDLE`, `RC_ARM`, `RC_RUN`, `RC_DONE`) and the default width constants.
- Sub-module `run_ctrl_cnt`: the cycle counter plus the run counter, with `clr`, `en` and `limit`/`runs` inputs, producing `wrap` and `last` outputs. The FSM stays in `run_ctrl`.

## Test plan
- Reset held 3 cycles -> `sreset=1`, `done=0`, `busy=0`, `cnt=0`; `start` pulse with `limit_val=4`, `runs=2` -> `sreset` high only in cycle 1, `tick` at cycles 6 and 11, `done` from cycle 12, `run_idx=2`.
- `limit_val=0`, `runs=3` -> `tick` high 3 consecutive cycles, `done` at cycle 5.
- `runs=0`, `limit_val=2` -> `tick` every 3rd cycle for 1000 cycles, no `done`, `run_idx` wraps 255 -> 0.
- `abort` at cnt=2 of run 1 (`limit_val=9`) -> IDLE next cycle, `sreset=1`, `done` never high; `start` and `abort` together in DONE -> IDLE.
- `start` re-pulsed mid-RUN and `limit_val` changed mid-RUN -> no effect, `done` timing unchanged; `start` in DONE -> ARM restarts the sequence with `cnt=0`.
- With `RUN_CTRL_PAUSE_EN`, `pause` for 5 cycles at cnt=3 (`limit_val=7`, `runs=1`) -> `cnt` holds at 3, `done` delayed by exactly 5 cycles.
